// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared pc_en codes, opcodes, condition codes, flag indices and FSM states for pc_sequencer
package pc_sequencer_pkg;
  localparam logic [1:0] PC_HOLD = 2'b00, PC_INC = 2'b01, PC_LOAD = 2'b10, PC_REL = 2'b11;
  localparam logic [3:0] OP_BCOND = 4'b1100, OP_JCOND = 4'b0100, JSUB_COND = 4'b1100;
  localparam logic [3:0] CC_EQ = 4'h0, CC_NE = 4'h1, CC_CS = 4'h2, CC_CC = 4'h3;
  localparam logic [3:0] CC_HI = 4'h4, CC_LS = 4'h5, CC_GT = 4'h6, CC_LE = 4'h7;
  localparam logic [3:0] CC_FS = 4'h8, CC_FC = 4'h9, CC_LO = 4'ha, CC_HS = 4'hb;
  localparam logic [3:0] CC_LT = 4'hc, CC_GE = 4'hd, CC_UC = 4'he, CC_NV = 4'hf;
  localparam int F_C = 4, F_L = 3, F_F = 2, F_Z = 1, F_N = 0;
  localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_REGRD = 3'd3;
  localparam logic [2:0] S_RESOLVE = 3'd4, S_UPDATE = 3'd5, S_HALT = 3'd6;
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: pc counter, instruction memory, register read and execute signals of pc_sequencer
interface pc_sequencer_if #(parameter int ADDR_W = 16, parameter int DATA_W = 16);
  logic [ADDR_W-1:0] pc;
  logic [1:0] pc_en;
  logic [ADDR_W-1:0] pc_newAdr;
  logic [ADDR_W-1:0] pc_imm;
  logic imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic imem_ack;
  logic [DATA_W-1:0] imem_data;
  logic [3:0] rf_raddr;
  logic [DATA_W-1:0] rf_rdata;
  logic [4:0] flags;
  logic ex_valid;
  logic [DATA_W-1:0] ex_instr;
  logic ex_ready;
  modport master (
    input pc, imem_ack, imem_data, rf_rdata, flags, ex_ready,
    output pc_en, pc_newAdr, pc_imm, imem_req, imem_addr, rf_raddr, ex_valid, ex_instr
  );
  modport slave (
    output pc, imem_ack, imem_data, rf_rdata, flags, ex_ready,
    input pc_en, pc_newAdr, pc_imm, imem_req, imem_addr, rf_raddr, ex_valid, ex_instr
  );
endinterface

// File: rtl/pc_sequencer_cond_eval.sv
// cond_eval: branch condition code against {C,L,F,Z,N} flags -> taken
module cond_eval
  import pc_sequencer_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [4:0] flags,
  output logic       taken
);
  logic c, l, f, z, n;
  logic [15:0] t;
  assign c = flags[F_C];
  assign l = flags[F_L];
  assign f = flags[F_F];
  assign z = flags[F_Z];
  assign n = flags[F_N];
  assign t = {1'b0, 1'b1, n | z, !n & !z, l | z, !l & !z, !f, f, !n, n, !l, l, !c, c, !z, z};
  assign taken = t[cond];
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/decode/branch sequencer driving the pc update code; PCSEQ_SINGLE_STEP_EN adds a step-gated HALT state
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input logic clk,
  input logic reset,
  input logic step,
  pc_sequencer_if.master bus
);
  logic [2:0] state;
  logic req;
  logic [DATA_W-1:0] ir;
  logic [1:0] code;
  logic [ADDR_W-1:0] new_adr, imm, target;
  logic is_b, is_j, taken;
  assign is_b = ir[15:12] == OP_BCOND;
  assign is_j = ir[15:12] == OP_JCOND && ir[7:4] == JSUB_COND;
  cond_eval u_cond (.cond(ir[11:8]), .flags(bus.flags), .taken(taken));
  assign bus.imem_req = req;
  assign bus.imem_addr = bus.pc;
  assign bus.pc_en = state == S_UPDATE ? code : PC_HOLD;
  assign bus.pc_newAdr = new_adr;
  assign bus.pc_imm = imm;
  assign bus.rf_raddr = ir[3:0];
  assign bus.ex_valid = state == S_EXEC;
  assign bus.ex_instr = ir;
`ifndef PCSEQ_SINGLE_STEP_EN
  logic unused_step;
  assign unused_step = step;
`endif
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_FETCH;
      req <= 1'b0;
      ir <= '0;
      code <= PC_HOLD;
      new_adr <= '0;
      imm <= '0;
      target <= '0;
    end else begin
      case (state)
        S_FETCH:
          if (req && bus.imem_ack) begin
            req <= 1'b0;
            ir <= bus.imem_data;
            state <= S_DECODE;
          end else req <= 1'b1;
        S_DECODE: state <= is_b ? S_RESOLVE : is_j ? S_REGRD : S_EXEC;
        S_EXEC:
          if (bus.ex_ready) begin
            code <= PC_INC;
            state <= S_UPDATE;
          end
        S_REGRD: begin
          target <= bus.rf_rdata[ADDR_W-1:0];
          state <= S_RESOLVE;
        end
        S_RESOLVE: begin
          code <= !taken ? PC_INC : is_b ? PC_REL : PC_LOAD;
          if (taken && is_b) imm <= {{(ADDR_W-8){ir[7]}}, ir[7:0]};
          if (taken && !is_b) new_adr <= target;
          state <= S_UPDATE;
        end
`ifdef PCSEQ_SINGLE_STEP_EN
        S_UPDATE: state <= S_HALT;
        S_HALT:
          if (step) begin
            req <= 1'b1;
            state <= S_FETCH;
          end
`else
        S_UPDATE: begin
          req <= 1'b1;
          state <= S_FETCH;
        end
`endif
        default: state <= S_FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed self-checking bench for pc_sequencer (default build and PCSEQ_SINGLE_STEP_EN)
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic reset;
  logic step;
  int n_chk = 0;
  int n_fail = 0;
  pc_sequencer_if #(.ADDR_W(16), .DATA_W(16)) bus ();
  pc_sequencer #(.ADDR_W(16), .DATA_W(16)) dut (.clk(clk), .reset(reset), .step(step), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic next_fetch(input logic [15:0] new_pc);
    bus.pc = new_pc;
`ifdef PCSEQ_SINGLE_STEP_EN
    tick();
    check("halt_req", 32'(bus.imem_req), 32'h0);
    check("halt_pc_en", 32'(bus.pc_en), 32'h0);
    tick();
    check("halt_stay_req", 32'(bus.imem_req), 32'h0);
    step = 1'b1;
    tick();
    step = 1'b0;
`else
    step = 1'b1;
    tick();
    step = 1'b0;
`endif
    check("fetch_req", 32'(bus.imem_req), 32'h1);
    check("fetch_addr", 32'(bus.imem_addr), 32'(new_pc));
    check("fetch_pc_en", 32'(bus.pc_en), 32'h0);
  endtask
  task automatic branch(input logic [15:0] instr, input logic [4:0] f, input logic [15:0] rdata);
    bus.imem_ack = 1'b1;
    bus.imem_data = instr;
    bus.flags = f;
    bus.rf_rdata = rdata;
    tick();
    bus.imem_ack = 1'b0;
    check("dec_pc_en", 32'(bus.pc_en), 32'h0);
    tick();
    check("mid_pc_en", 32'(bus.pc_en), 32'h0);
    tick();
  endtask
  initial begin
    reset = 1'b0;
    step = 1'b0;
    bus.pc = 16'h0010;
    bus.imem_ack = 1'b0;
    bus.imem_data = '0;
    bus.rf_rdata = '0;
    bus.flags = '0;
    bus.ex_ready = 1'b0;
    tick();
    tick();
    check("rst_req", 32'(bus.imem_req), 32'h0);
    check("rst_pc_en", 32'(bus.pc_en), 32'h0);
    check("rst_ex_valid", 32'(bus.ex_valid), 32'h0);
    check("rst_ex_instr", 32'(bus.ex_instr), 32'h0);
    check("rst_newadr", 32'(bus.pc_newAdr), 32'h0);
    check("rst_imm", 32'(bus.pc_imm), 32'h0);
    check("rst_raddr", 32'(bus.rf_raddr), 32'h0);
    reset = 1'b1;
    tick();
    check("first_req", 32'(bus.imem_req), 32'h1);
    check("first_addr", 32'(bus.imem_addr), 32'h0010);
    reset = 1'b0;
    #1;
    check("async_rst_req", 32'(bus.imem_req), 32'h0);
    check("async_rst_pc_en", 32'(bus.pc_en), 32'h0);
    reset = 1'b1;
    tick();
    check("refetch_req", 32'(bus.imem_req), 32'h1);
    check("refetch_addr", 32'(bus.imem_addr), 32'h0010);
    bus.imem_ack = 1'b1;
    bus.imem_data = 16'h0123;
    bus.ex_ready = 1'b1;
    tick();
    bus.imem_ack = 1'b0;
    check("alu_dec_req", 32'(bus.imem_req), 32'h0);
    check("alu_dec_valid", 32'(bus.ex_valid), 32'h0);
    tick();
    check("alu_ex_valid", 32'(bus.ex_valid), 32'h1);
    check("alu_ex_instr", 32'(bus.ex_instr), 32'h0123);
    check("alu_ex_pc_en", 32'(bus.pc_en), 32'h0);
    tick();
    check("alu_upd_valid", 32'(bus.ex_valid), 32'h0);
    check("alu_upd_pc_en", 32'(bus.pc_en), 32'h1);
    next_fetch(16'h0020);
    branch(16'hC0FE, 5'b00010, 16'h0);
    check("beq_t_pc_en", 32'(bus.pc_en), 32'h3);
    check("beq_t_imm", 32'(bus.pc_imm), 32'hFFFE);
    next_fetch(16'h001E);
    branch(16'hC0FE, 5'b00000, 16'h0);
    check("beq_nt_pc_en", 32'(bus.pc_en), 32'h1);
    check("beq_nt_imm", 32'(bus.pc_imm), 32'hFFFE);
    next_fetch(16'h001F);
    branch(16'hCD05, 5'b00001, 16'h0);
    check("bge_t_pc_en", 32'(bus.pc_en), 32'h3);
    check("bge_t_imm", 32'(bus.pc_imm), 32'h0005);
    next_fetch(16'h0024);
    bus.imem_ack = 1'b1;
    bus.imem_data = 16'h4EC5;
    bus.rf_rdata = 16'h1234;
    bus.flags = 5'b00000;
    tick();
    bus.imem_ack = 1'b0;
    check("juc_raddr", 32'(bus.rf_raddr), 32'h5);
    check("juc_dec_pc_en", 32'(bus.pc_en), 32'h0);
    tick();
    check("juc_regrd_pc_en", 32'(bus.pc_en), 32'h0);
    tick();
    check("juc_res_pc_en", 32'(bus.pc_en), 32'h0);
    tick();
    check("juc_pc_en", 32'(bus.pc_en), 32'h2);
    check("juc_newadr", 32'(bus.pc_newAdr), 32'h1234);
    next_fetch(16'h1234);
    bus.imem_ack = 1'b1;
    bus.imem_data = 16'h4FC3;
    bus.rf_rdata = 16'hBEEF;
    tick();
    bus.imem_ack = 1'b0;
    tick();
    tick();
    tick();
    check("jnv_pc_en", 32'(bus.pc_en), 32'h1);
    check("jnv_newadr", 32'(bus.pc_newAdr), 32'h1234);
    next_fetch(16'h1235);
    bus.ex_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("wait_ack_req", 32'(bus.imem_req), 32'h1);
      check("wait_ack_pc_en", 32'(bus.pc_en), 32'h0);
    end
    bus.imem_ack = 1'b1;
    bus.imem_data = 16'h0456;
    tick();
    bus.imem_ack = 1'b0;
    tick();
    check("wait_rdy_valid0", 32'(bus.ex_valid), 32'h1);
    check("wait_rdy_pc_en0", 32'(bus.pc_en), 32'h0);
    tick();
    check("wait_rdy_valid1", 32'(bus.ex_valid), 32'h1);
    check("wait_rdy_instr", 32'(bus.ex_instr), 32'h0456);
    check("wait_rdy_pc_en1", 32'(bus.pc_en), 32'h0);
    bus.ex_ready = 1'b1;
    tick();
    check("wait_upd_valid", 32'(bus.ex_valid), 32'h0);
    check("wait_upd_pc_en", 32'(bus.pc_en), 32'h1);
    next_fetch(16'h1236);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Control-side initiator for the program counter. Drives the counter's 2-bit update code, absolute target and relative displacement, one update per instruction.
- Fetches each instruction at the current PC over a req/ack instruction-memory handshake. Hands non-control instructions to the execute stage (valid/ready). Resolves Bcond/Jcond against the ALU flags.
- Sits between the program counter, instruction memory, register file read port and the ALU/execute stage.

Parameters:
- ADDR_W, 16: PC / address width.
- DATA_W, 16: instruction and register width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- pc  in  ADDR_W  current program counter value.
- pc_en  out  2  update code: 00 hold, 01 increment, 10 load pc_newAdr, 11 add pc_imm.
- pc_newAdr  out  ADDR_W  absolute jump target.
- pc_imm  out  ADDR_W  sign-extended branch displacement.
- imem_req  out  1  fetch request.
- imem_addr  out  ADDR_W  fetch address.
- imem_ack  in  1  fetch data valid.
- imem_data  in  DATA_W  instruction word.
- rf_raddr  out  4  register index for Jcond target.
- rf_rdata  in  DATA_W  register data, valid one cycle after rf_raddr.
- flags  in  5  {C,L,F,Z,N} from ALU, sampled at resolve.
- ex_valid  out  1  instruction available to execute.
- ex_instr  out  DATA_W  instruction to execute.
- ex_ready  in  1  execute accepted / done.
- step  in  1  single-step pulse (used only with the optional feature).

Behaviour:
- Reset (async, reset=0): state FETCH; pc_en=00; pc_newAdr=0; pc_imm=0; imem_req=0; ex_valid=0; ex_instr=0; rf_raddr=0.
- Reset mid-transaction abandons the fetch/execute in progress; imem_req drops immediately. No PC update is issued.
- FETCH:
  - imem_req=1, imem_addr=pc, held until imem_ack.
  - On ack, latch imem_data into the instruction register and go to DECODE. Ack with no req is ignored.
- DECODE (1 cycle):
  - Bcond: [15:12]=1100, cond=[11:8], disp=[7:0]. Go to RESOLVE.
  - Jcond: [15:12]=0100 and [7:4]=1100, cond=[11:8], Rtarget=[3:0]. Drive rf_raddr=Rtarget and go to REGRD.
  - Otherwise: go to EXEC.
- EXEC:
  - ex_valid=1 and ex_instr stable until ex_ready. Transfer on the cycle ex_valid&ex_ready.
  - Next cycle ex_valid=0; go to UPDATE with code 01.
  - ex_ready while ex_valid=0 is ignored.
- REGRD (1 cycle): capture rf_rdata as the target; go to RESOLVE.
- RESOLVE (1 cycle): evaluate cond on flags.
  - EQ 0000 Z; NE 0001 !Z; CS 0010 C; CC 0011 !C; HI 0100 L; LS 0101 !L; GT 0110 N; LE 0111 !N.
  - FS 1000 F; FC 1001 !F; LO 1010 !L&!Z; HS 1011 L|Z; LT 1100 !N&!Z; GE 1101 N|Z; UC 1110 1; 1111 0.
  - Bcond taken: code 11, pc_imm = sign-extend(disp) to ADDR_W.
  - Jcond taken: code 10, pc_newAdr = target[ADDR_W-1:0].
  - Not taken: code 01.
- UPDATE (1 cycle): pc_en = selected code for exactly this cycle; pc_newAdr/pc_imm valid in the same cycle. Then go to FETCH.
- pc_en=00 in every other state.
- Next FETCH issues imem_addr with the updated pc (counter registers on the UPDATE edge).
- Arithmetic: displacement is in words, 2's complement. Add wraps modulo 2^ADDR_W (the counter performs the add; this block only sign-extends).
- Latency, zero-wait memory, ready-high execute:
  - ALU op: 4 cycles (FETCH, DECODE, EXEC, UPDATE).
  - Bcond: 4 cycles.
  - Jcond: 5 cycles.

Optional Feature:
- Macro PCSEQ_SINGLE_STEP_EN.
- Defined: after UPDATE, enter state HALT (all outputs idle, pc_en=00). Leave HALT on the first cycle step=1, going to FETCH. Reset still enters FETCH directly.
- Not defined: no HALT state; the step port is ignored; UPDATE goes straight to FETCH.

Decomposition:
- Shared package holds:
  - pc_en code constants (PC_HOLD, PC_INC, PC_LOAD, PC_REL).
  - Opcode constants (OP_BCOND=4'b1100, OP_JCOND=4'b0100, JSUB_COND=4'b1100).
  - Condition-code constants and the flag-index constants for {C,L,F,Z,N}.
  - FSM state enum.
- One natural sub-module: cond_eval (combinational cond+flags -> taken), reusable by other control blocks.

Test Plan:
- Reset with reset=0 mid-FETCH (imem_req=1) -> imem_req=0 and pc_en=00 immediately; after release, first FETCH uses imem_addr=pc.
- pc=0x0010, instr ADD (0x0123), ack immediate, ex_ready=1 -> exactly one cycle pc_en=01; ex_instr=0x0123 seen with ex_valid for one transfer.
- pc=0x0020, Bcond EQ disp=0xFE (0xC0FE), Z=1 -> pc_en=11, pc_imm=0xFFFE. Same with Z=0 -> pc_en=01.
- Jcond UC R5 (0x4EC5), rf_rdata=0x1234 -> rf_raddr=5, then pc_en=10, pc_newAdr=0x1234, 5 cycles after req.
- imem_ack delayed 3 cycles, ex_ready delayed 2 cycles -> req/valid held stable, no pc_en pulse until transfer, exactly one update per instruction.
- With PCSEQ_SINGLE_STEP_EN, two ALU instrs and step pulsed once -> exactly one further fetch/update, then stays in HALT.
